// File: rtl/lsu_if.sv
// Bus bundle between the LSU and its neighbours: execute-side request,
// data-memory port and writeback response.
interface lsu_if;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_valid, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  // master: environment (execute, memory, writeback); slave: the LSU itself
  modport master (
    output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
           mem_rdata, out_ready,
    input  in_ready, mem_valid, mem_wr, mem_addr, mem_wdata, mem_wmask,
           out_valid, out_rdata, out_err
  );
  modport slave (
    input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
           mem_rdata, out_ready,
    output in_ready, mem_valid, mem_wr, mem_addr, mem_wdata, mem_wmask,
           out_valid, out_rdata, out_err
  );
endinterface

// File: rtl/lsu_stage.sv
// Single-outstanding load/store unit: checks alignment, drives the data memory
// port for MEM_WAIT+1 cycles, extends load data and hands it to writeback.
module lsu_stage #(
  parameter int MEM_WAIT = 0
) (
  input logic  clock,
  input logic  reset_n,
  lsu_if.slave bus
);
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ld_q, st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;

  logic          f3_ok, mis, err;
  logic [31:0]   lane_wdata, ext;
  logic [7:0]    rb;
  logic [15:0]   rh;

  always_comb begin
    f3_ok = 1'b1;
    if (bus.in_load)       f3_ok = bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (bus.in_store) f3_ok = bus.in_funct3 inside {3'b000, 3'b001, 3'b010};
    mis = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
          ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
    err = (bus.in_load && bus.in_store) ||
          ((bus.in_load || bus.in_store) && (!f3_ok || mis));
    case (bus.in_funct3[1:0])
      2'b00:   lane_wdata = {4{bus.in_wdata[7:0]}};
      2'b01:   lane_wdata = {2{bus.in_wdata[15:0]}};
      default: lane_wdata = bus.in_wdata;
    endcase
  end

  // Load extraction works off the captured address/size, not the live inputs
  always_comb begin
    case (lane_q)
      2'd0:    rb = bus.mem_rdata[7:0];
      2'd1:    rb = bus.mem_rdata[15:8];
      2'd2:    rb = bus.mem_rdata[23:16];
      default: rb = bus.mem_rdata[31:24];
    endcase
    rh = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rb[7]}}, rb};
      3'b001:  ext = {{16{rh[15]}}, rh};
      3'b100:  ext = {24'd0, rb};
      3'b101:  ext = {16'd0, rh};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ld_q          <= 1'b0;
      st_q          <= 1'b0;
      f3_q          <= 3'd0;
      lane_q        <= 2'd0;
      bus.in_ready  <= 1'b1;
      bus.mem_valid <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_wmask <= 3'd0;
      bus.out_valid <= 1'b0;
      bus.out_rdata <= 32'd0;
      bus.out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ld_q         <= bus.in_load;
          st_q         <= bus.in_store;
          f3_q         <= bus.in_funct3;
          lane_q       <= bus.in_addr[1:0];
          bus.in_ready <= 1'b0;
          if (err || !(bus.in_load || bus.in_store)) begin
            state         <= RESP;
            bus.out_valid <= 1'b1;
            bus.out_err   <= err;
            bus.out_rdata <= 32'd0;
          end else begin
            state         <= ACCESS;
            cnt           <= CW'(MEM_WAIT);
            bus.mem_valid <= 1'b1;
            // write strobe lands only in the final access cycle
            bus.mem_wr    <= bus.in_store && (MEM_WAIT == 0);
            bus.mem_addr  <= {bus.in_addr[31:2], 2'b00};
            bus.mem_wdata <= lane_wdata;
            bus.mem_wmask <= {1'b0, bus.in_funct3[1:0]};
          end
        end
        ACCESS: if (cnt == '0) begin
          state         <= RESP;
          bus.mem_valid <= 1'b0;
          bus.mem_wr    <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_err   <= 1'b0;
          bus.out_rdata <= ld_q ? ext : 32'd0;
        end else begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) bus.mem_wr <= st_q;
        end
        RESP: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: three instances (MEM_WAIT 0/3/2) driven in turn.
module tb_lsu_stage;
  logic clock, reset_n;
  int   tests = 0, fails = 0;

  lsu_if b0 (), b3 (), b2 ();
  lsu_stage #(.MEM_WAIT(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(b0.slave));
  lsu_stage #(.MEM_WAIT(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(b3.slave));
  lsu_stage #(.MEM_WAIT(2)) dut2 (.clock(clock), .reset_n(reset_n), .bus(b2.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op to the MEM_WAIT=0 instance; returns 1 time unit after the accept edge
  task automatic issue0(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    b0.in_valid = 1'b1; b0.in_load = ld; b0.in_store = st;
    b0.in_funct3 = f3; b0.in_addr = a; b0.in_wdata = wd;
    tick();
    b0.in_valid = 1'b0; b0.in_load = 1'b0; b0.in_store = 1'b0;
  endtask

  task automatic idle_bus(input string who);
    if (who == "b3") begin
      b3.in_valid = 0; b3.in_load = 0; b3.in_store = 0; b3.in_funct3 = 0;
      b3.in_addr = 0; b3.in_wdata = 0; b3.mem_rdata = 0; b3.out_ready = 1;
    end else if (who == "b2") begin
      b2.in_valid = 0; b2.in_load = 0; b2.in_store = 0; b2.in_funct3 = 0;
      b2.in_addr = 0; b2.in_wdata = 0; b2.mem_rdata = 0; b2.out_ready = 1;
    end else begin
      b0.in_valid = 0; b0.in_load = 0; b0.in_store = 0; b0.in_funct3 = 0;
      b0.in_addr = 0; b0.in_wdata = 0; b0.mem_rdata = 0; b0.out_ready = 1;
    end
  endtask

  initial begin
    idle_bus("b0"); idle_bus("b3"); idle_bus("b2");
    reset_n = 1'b0;
    tick(); tick();
    chk1 ("rst_in_ready",  b0.in_ready, 1'b1);
    chk1 ("rst_mem_valid", b0.mem_valid, 1'b0);
    chk1 ("rst_mem_wr",    b0.mem_wr, 1'b0);
    chk32("rst_mem_addr",  b0.mem_addr, 32'h0);
    chk1 ("rst_out_valid", b0.out_valid, 1'b0);
    chk32("rst_out_rdata", b0.out_rdata, 32'h0);
    chk1 ("rst_out_err",   b0.out_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // store word, single access cycle
    issue0(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
    chk1 ("sw_mem_valid", b0.mem_valid, 1'b1);
    chk1 ("sw_mem_wr",    b0.mem_wr, 1'b1);
    chk32("sw_mem_addr",  b0.mem_addr, 32'h8000_0010);
    chk32("sw_mem_wdata", b0.mem_wdata, 32'hDEAD_BEEF);
    chk32("sw_mem_wmask", 32'(b0.mem_wmask), 32'd2);
    chk1 ("sw_in_ready",  b0.in_ready, 1'b0);
    tick();
    chk1 ("sw_out_valid", b0.out_valid, 1'b1);
    chk1 ("sw_mem_wr_off",b0.mem_wr, 1'b0);
    chk32("sw_out_rdata", b0.out_rdata, 32'h0);
    chk1 ("sw_out_err",   b0.out_err, 1'b0);
    tick();
    chk1 ("sw_back_idle", b0.in_ready, 1'b1);
    chk1 ("sw_ov_drop",   b0.out_valid, 1'b0);

    // lb / lbu from the top byte lane
    b0.mem_rdata = 32'h8011_2233;
    issue0(1'b1, 1'b0, 3'b000, 32'h8000_0013, 32'h0);
    chk1 ("lb_mem_valid", b0.mem_valid, 1'b1);
    chk1 ("lb_mem_wr",    b0.mem_wr, 1'b0);
    chk32("lb_mem_addr",  b0.mem_addr, 32'h8000_0010);
    tick();
    chk32("lb_rdata",     b0.out_rdata, 32'hFFFF_FF80);
    tick();
    issue0(1'b1, 1'b0, 3'b100, 32'h8000_0013, 32'h0);
    tick();
    chk32("lbu_rdata",    b0.out_rdata, 32'h0000_0080);
    tick();

    // lh from the upper half, then misaligned lh
    b0.mem_rdata = 32'h9ABC_1234;
    issue0(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0);
    tick();
    chk32("lh_rdata",     b0.out_rdata, 32'hFFFF_9ABC);
    tick();
    issue0(1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0);
    chk1 ("lhmis_mem_valid", b0.mem_valid, 1'b0);
    chk1 ("lhmis_out_valid", b0.out_valid, 1'b1);
    chk1 ("lhmis_out_err",   b0.out_err, 1'b1);
    chk32("lhmis_rdata",     b0.out_rdata, 32'h0);
    tick();

    // illegal store funct3, load+store both set, and neither (bypass)
    issue0(1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h1);
    chk1 ("sbad_err",   b0.out_err, 1'b1);
    chk1 ("sbad_mem",   b0.mem_valid, 1'b0);
    tick();
    issue0(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h1);
    chk1 ("ldst_err",   b0.out_err, 1'b1);
    tick();
    issue0(1'b0, 1'b0, 3'b010, 32'h8000_0001, 32'h1);
    chk1 ("byp_valid",  b0.out_valid, 1'b1);
    chk1 ("byp_err",    b0.out_err, 1'b0);
    chk1 ("byp_mem",    b0.mem_valid, 1'b0);
    tick();

    // lw held in RESP under writeback backpressure
    b0.out_ready = 1'b0;
    b0.mem_rdata = 32'h1357_9BDF;
    issue0(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0);
    tick();
    b0.mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk1 ("hold_out_valid", b0.out_valid, 1'b1);
      chk32("hold_rdata",     b0.out_rdata, 32'h1357_9BDF);
      chk1 ("hold_in_ready",  b0.in_ready, 1'b0);
      tick();
    end
    b0.out_ready = 1'b1;
    tick();
    chk1 ("hold_idle",   b0.in_ready, 1'b1);
    chk1 ("hold_ov_off", b0.out_valid, 1'b0);

    // MEM_WAIT=3 store byte: 4 access cycles, write only in the last
    b3.in_valid = 1'b1; b3.in_store = 1'b1; b3.in_funct3 = 3'b000;
    b3.in_addr = 32'h8000_0001; b3.in_wdata = 32'h0000_005A;
    tick();
    b3.in_valid = 1'b0; b3.in_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1 ("sb3_mem_valid", b3.mem_valid, 1'b1);
      chk1 ("sb3_mem_wr",    b3.mem_wr, (i == 3));
      chk32("sb3_mem_wdata", b3.mem_wdata, 32'h5A5A_5A5A);
      chk32("sb3_mem_wmask", 32'(b3.mem_wmask), 32'd0);
      chk32("sb3_mem_addr",  b3.mem_addr, 32'h8000_0000);
      tick();
    end
    chk1 ("sb3_mem_done",  b3.mem_valid, 1'b0);
    chk1 ("sb3_out_valid", b3.out_valid, 1'b1);
    tick();

    // reset in the middle of a MEM_WAIT=2 store aborts it before the write
    b2.in_valid = 1'b1; b2.in_store = 1'b1; b2.in_funct3 = 3'b010;
    b2.in_addr = 32'h8000_0020; b2.in_wdata = 32'h1234_5678;
    tick();
    b2.in_valid = 1'b0; b2.in_store = 1'b0;
    chk1 ("rs_mem_valid", b2.mem_valid, 1'b1);
    chk1 ("rs_mem_wr0",   b2.mem_wr, 1'b0);
    tick();
    chk1 ("rs_mem_wr1",   b2.mem_wr, 1'b0);
    reset_n = 1'b0;
    tick();
    chk1 ("rs_mem_wr",    b2.mem_wr, 1'b0);
    chk1 ("rs_mem_valid0",b2.mem_valid, 1'b0);
    chk32("rs_mem_addr",  b2.mem_addr, 32'h0);
    chk32("rs_mem_wdata", b2.mem_wdata, 32'h0);
    chk1 ("rs_in_ready",  b2.in_ready, 1'b1);
    chk1 ("rs_out_valid", b2.out_valid, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1 ("rs_no_wr_after", b2.mem_wr, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
